fetch_pc_unit: RTL and testbench

// - Program-counter and instruction-fetch stage; consumes the branch decision (b_out) from branch_logic plus jump controls from EX.
// - Holds the architectural fetch PC and runs the req/ack handshake to instruction memory.
// - Presents each fetched instruction to decode, redirects on taken branch/JAL/JALR, and flushes the wrong-path fetch.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_target_calc.sv | 45 ++++
 rtl/fetch_pc_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
//   fetch_state_t : fetch FSM states
//   redirect_t    : which control-transfer source won redirect arbitration
//   RESET_PC_DEFAULT, INSTR_BYTES : boot address and instruction size
//   is_misaligned : halfword-misalignment test on a redirect target
package cpu_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_IDLE,
    S_FETCH,
    S_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JAL,
    RD_JALR
  } redirect_t;

  // Bit 0 is either cleared (JALR) or architecturally zero, so only bit 1
  // can leave a target off a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] target_lsb);
    return target_lsb[1];
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect arbitration and target generation.
//   in  ex_valid, branch_taken, jal, jalr : EX-stage control-transfer flags
//   in  ex_pc, imm, rs1_data              : operands for target generation
//   out kind       : winning redirect source (jalr > jal > branch)
//   out target     : redirect address (modulo 2^XLEN)
//   out misaligned : target is not 4-byte aligned (only meaningful with kind)
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            ex_valid,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output redirect_t       kind,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_sum;

  always_comb begin
    jalr_sum = rs1_data + imm;
    rel_sum  = ex_pc + imm;
    kind     = RD_NONE;
    target   = rel_sum;
    if (ex_valid) begin
      if (jalr) begin
        kind   = RD_JALR;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (jal) begin
        kind = RD_JAL;
      end else if (branch_taken) begin
        kind = RD_BRANCH;
      end
    end
    misaligned = (kind != RD_NONE) && is_misaligned(target[1:0]);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage.
//   in  clk, rst (async, active-high)
//   in  branch_taken, jal, jalr, ex_valid, ex_pc, imm, rs1_data : redirect sources
//   in  stall    : decode cannot accept, do not issue a new fetch
//   in  halt_req : stop fetching (after any outstanding request completes)
//   in  imem_rdata, imem_ack : instruction memory response
//   out imem_req, imem_addr  : instruction memory request (addr tracks pc)
//   out pc, instr, instr_pc, instr_valid : fetch PC and fetched word to decode
//   out flush      : one-cycle pulse per accepted redirect
//   out halted     : sticky, fetch stopped
//   out misaligned : sticky, a redirect targeted a non-word address
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            stall,
  input  logic            halt_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            flush,
  output logic            halted,
  output logic            misaligned
);

  fetch_state_t    state, state_d;
  redirect_t       rd_kind;
  logic [XLEN-1:0] rd_target;
  logic            rd_mis;

  logic [XLEN-1:0] pc_d;
  logic            drop_pending, drop_d;
  logic            halt_wait, halt_wait_d;
  logic            load_instr, flush_d, mis_d;
  logic            halt_any, take;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .ex_valid     (ex_valid),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .ex_pc        (ex_pc),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .kind         (rd_kind),
    .target       (rd_target),
    .misaligned   (rd_mis)
  );

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    drop_d      = drop_pending;
    halt_wait_d = halt_wait;
    load_instr  = 1'b0;
    flush_d     = 1'b0;
    mis_d       = misaligned;
    imem_req    = (state == S_FETCH);
    // A halt request (current or remembered) masks every redirect.
    halt_any    = halt_req | halt_wait;
    take        = (rd_kind != RD_NONE) && !halt_any && (state != S_HALT);

    if (take && rd_mis) begin
      // Bad target: leave pc alone and stop; a late ack lands in S_HALT
      // where it is ignored.
      mis_d       = 1'b1;
      state_d     = S_HALT;
      drop_d      = 1'b0;
      halt_wait_d = 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            if (take) begin
              pc_d    = rd_target;
              flush_d = 1'b1;
            end
            state_d = S_FETCH;
          end
        end
        S_IDLE: begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            if (take) begin
              pc_d    = rd_target;
              flush_d = 1'b1;
            end
            state_d = stall ? S_IDLE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            drop_d      = 1'b0;
            halt_wait_d = 1'b0;
            if (halt_any) begin
              state_d = S_HALT;
            end else begin
              if (take) begin
                pc_d    = rd_target;
                flush_d = 1'b1;
              end else if (!drop_pending) begin
                load_instr = 1'b1;
                pc_d       = pc + XLEN'(INSTR_BYTES);
              end
              state_d = stall ? S_IDLE : S_FETCH;
            end
          end else if (halt_req) begin
            halt_wait_d = 1'b1;
          end else if (take) begin
            // Request stays up; its eventual word belongs to the old path.
            pc_d    = rd_target;
            flush_d = 1'b1;
            drop_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      flush        <= 1'b0;
      misaligned   <= 1'b0;
      drop_pending <= 1'b0;
      halt_wait    <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      instr_valid  <= load_instr;
      flush        <= flush_d;
      misaligned   <= mis_d;
      drop_pending <= drop_d;
      halt_wait    <= halt_wait_d;
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0, jal = 1'b0, jalr = 1'b0, ex_valid = 1'b0;
  logic [31:0] ex_pc = '0, imm = '0, rs1_data = '0;
  logic        stall = 1'b0, halt_req = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid, flush, halted, misaligned;
  logic [31:0] imem_addr, pc, instr, instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .imm(imm), .rs1_data(rs1_data),
    .stall(stall), .halt_req(halt_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .flush(flush),
    .halted(halted), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetcher is in its life cycle, plus the
  // architecturally visible registers.
  bit          m_booting, m_fetching, m_stopped;
  bit          m_drop, m_halt_wait;
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_vld, m_flush, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booting = 1; m_fetching = 0; m_stopped = 0;
    m_drop = 0; m_halt_wait = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_vld = 0; m_flush = 0; m_mis = 0;
  endtask

  task automatic check_model();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_fetching});
    if (m_fetching) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_vld});
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("halted", {31'b0, halted}, {31'b0, m_stopped});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  // Advance one clock: predict from the rules, clock the DUT, compare.
  task automatic cycle();
    bit          wants, blocked, take;
    logic [31:0] tgt;
    bit          nb, nf, ns, nd, nh, nv, nfl, nm;
    logic [31:0] npc, ni, nipc;
    wants   = ex_valid && (jalr || jal || branch_taken);
    tgt     = jalr ? ((rs1_data + imm) & ~32'd1) : (ex_pc + imm);
    blocked = halt_req || m_halt_wait;
    take    = wants && !blocked && !m_stopped;
    nb = m_booting; nf = m_fetching; ns = m_stopped; nd = m_drop; nh = m_halt_wait;
    npc = m_pc; ni = m_instr; nipc = m_ipc; nv = 0; nfl = 0; nm = m_mis;
    if (rst) begin
      nb = 1; nf = 0; ns = 0; nd = 0; nh = 0; npc = 0; ni = 0; nipc = 0; nm = 0;
    end else if (m_stopped) begin
      // nothing moves once stopped
    end else if (take && tgt[1]) begin
      nm = 1; ns = 1; nb = 0; nf = 0; nd = 0; nh = 0;
    end else if (!m_fetching) begin
      if (halt_req) begin
        ns = 1; nb = 0;
      end else begin
        if (take) begin npc = tgt; nfl = 1; end
        nf = m_booting ? 1 : !stall;
        nb = 0;
      end
    end else if (imem_ack) begin
      nd = 0; nh = 0;
      if (blocked) begin
        ns = 1; nf = 0;
      end else begin
        if (take) begin npc = tgt; nfl = 1; end
        else if (!m_drop) begin ni = imem_rdata; nipc = m_pc; nv = 1; npc = m_pc + 4; end
        nf = !stall;
      end
    end else if (halt_req) begin
      nh = 1;
    end else if (take) begin
      npc = tgt; nfl = 1; nd = 1;
    end
    @(posedge clk);
    #1;
    m_booting = nb; m_fetching = nf; m_stopped = ns; m_drop = nd; m_halt_wait = nh;
    m_pc = npc; m_instr = ni; m_ipc = nipc; m_vld = nv; m_flush = nfl; m_mis = nm;
    check_model();
  endtask

  task automatic clear_ex();
    ex_valid = 0; jal = 0; jalr = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1; imem_ack = 0; stall = 0; halt_req = 0; clear_ex();
    #1;
    model_reset();
    check_model();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    int stopped_cycles;
    #2;
    // Reset state
    do_reset();
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // Zero-wait memory from reset
    imem_ack = 1; imem_rdata = $urandom;
    cycle();
    chk("zw_req", {31'b0, imem_req}, 32'h1);
    chk("zw_addr0", imem_addr, 32'h0);
    imem_rdata = $urandom; cycle();
    chk("zw_addr1", imem_addr, 32'h4);
    chk("zw_vld1", {31'b0, instr_valid}, 32'h1);
    chk("zw_ipc0", instr_pc, 32'h0);
    imem_rdata = $urandom; cycle();
    chk("zw_addr2", imem_addr, 32'h8);
    chk("zw_ipc1", instr_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin imem_rdata = $urandom; cycle(); end
    chk("br_wait_addr", imem_addr, 32'h14);

    // Branch back to 0x8 while the 0x14 fetch is outstanding
    imem_ack = 0;
    ex_valid = 1; branch_taken = 1; ex_pc = 32'h10; imm = 32'hFFFF_FFF8;
    cycle();
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_pc", pc, 32'h8);
    clear_ex();
    cycle();
    chk("br_flush_once", {31'b0, flush}, 32'h0);
    cycle();
    imem_ack = 1; imem_rdata = $urandom; cycle();
    chk("br_drop", {31'b0, instr_valid}, 32'h0);
    chk("br_readdr", imem_addr, 32'h8);

    // Stall for 4 cycles after the ack at 0x8
    stall = 1; imem_rdata = $urandom; cycle();
    chk("st_ipc", instr_pc, 32'h8);
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("st_req", {31'b0, imem_req}, 32'h0);
      chk("st_pc", pc, 32'hC);
    end
    stall = 0; cycle();
    chk("st_resume", imem_addr, 32'hC);
    imem_ack = 1; imem_rdata = $urandom; cycle();
    chk("st_ipc2", instr_pc, 32'hC);
    imem_ack = 0;

    // JAL and branch together: JAL wins, single flush
    ex_valid = 1; jal = 1; branch_taken = 1; ex_pc = 32'h20; imm = 32'h40;
    rs1_data = $urandom;
    cycle();
    chk("jal_pc", pc, 32'h60);
    chk("jal_flush", {31'b0, flush}, 32'h1);
    clear_ex(); cycle();
    chk("jal_flush_once", {31'b0, flush}, 32'h0);
    imem_ack = 1; imem_rdata = $urandom; cycle();
    chk("jal_drop", {31'b0, instr_valid}, 32'h0);
    imem_rdata = $urandom; cycle();
    chk("jal_ipc", instr_pc, 32'h60);
    imem_ack = 0;

    // Aligned JALR with bit 0 cleared
    ex_valid = 1; jalr = 1; rs1_data = 32'h101; imm = 32'h3;
    cycle();
    chk("jalr_pc", pc, 32'h104);
    chk("jalr_flush", {31'b0, flush}, 32'h1);
    chk("jalr_mis", {31'b0, misaligned}, 32'h0);
    clear_ex();
    imem_ack = 1; imem_rdata = $urandom; cycle();
    imem_ack = 0;

    // halt_req while a fetch is outstanding
    halt_req = 1; cycle();
    chk("hq_req", {31'b0, imem_req}, 32'h1);
    halt_req = 0; cycle();
    imem_ack = 1; imem_rdata = $urandom; cycle();
    chk("hq_halted", {31'b0, halted}, 32'h1);
    chk("hq_drop", {31'b0, instr_valid}, 32'h0);
    imem_ack = 0;
    do_reset();

    // Misaligned JALR target
    cycle();
    ex_valid = 1; jalr = 1; rs1_data = 32'h103; imm = 32'h0;
    cycle();
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    chk("mis_halted", {31'b0, halted}, 32'h1);
    chk("mis_flush", {31'b0, flush}, 32'h0);
    clear_ex();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); cycle();
      chk("mis_req", {31'b0, imem_req}, 32'h0);
      chk("mis_pc", pc, 32'h0);
    end
    do_reset();

    // Randomized traffic against the model
    stopped_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_rdata   = $urandom;
      imem_ack     = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 7) == 0);
      halt_req     = ($urandom_range(0, 249) == 0);
      ex_valid     = ($urandom_range(0, 7) == 0);
      jal          = 1'($urandom_range(0, 1));
      jalr         = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      ex_pc        = $urandom_range(0, 255) * 4;
      imm          = $urandom_range(0, 63) * 4 - 32'd128;
      rs1_data     = $urandom_range(0, 255) * 4 + $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) imm = imm | 32'h2;
      cycle();
      stopped_cycles = m_stopped ? stopped_cycles + 1 : 0;
      if (stopped_cycles > 3) begin
        do_reset();
        stopped_cycles = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
